sub_arbiter: RTL and testbench
==============================

Name: sub_arbiter

Overview:
- Shares one vector-subtract unit (3 x 32-bit lanes, out = x - y, FIFO in/out) between two requester streams, e.g. ray-origin minus vertex and edge setup.
- Front end: round-robin selection of a requester's FIFO head, presented to the subtract unit. A tag FIFO records the grant order.
- Back end: pops subtract results and routes each to the originating requester's result FIFO, in order.

Parameters:
- MAX_OUTSTANDING, 8: maximum accepted-but-not-routed operations; also the tag FIFO depth (power of 2, >=2).
- DATA_WIDTH, 32: lane width, signed two's complement.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state.
- req0_x / req0_y  in  3x DATA_WIDTH  requester 0 FIFO head operands.
- req0_empty  in  1  requester 0 FIFO empty.
- req0_rd_en  out  1  pop requester 0 FIFO.
- req1_x / req1_y / req1_empty / req1_rd_en  same as requester 0, for requester 1.
- sub_x / sub_y  out  3x DATA_WIDTH  operands to the subtract unit (its x, y).
- sub_empty  out  1  drives the subtract unit's in_empty.
- sub_rd_en  in  1  the subtract unit's in_rd_en.
- sub_out  in  3x DATA_WIDTH  subtract result FIFO head (first-word fall-through).
- sub_out_empty  in  1  subtract result FIFO empty.
- sub_out_rd_en  out  1  pop subtract result FIFO.
- res0_dout  out  3x DATA_WIDTH  result to requester 0's result FIFO.
- res0_wr_en  out  1  write strobe to requester 0's result FIFO.
- res0_full  in  1  requester 0's result FIFO full.
- res1_dout / res1_wr_en / res1_full  same as requester 0, for requester 1.

Behaviour:
- Reset (reset=0, async): last_grant=1, so requester 0 wins the first tie. Tag FIFO empty; outstanding count=0; back FSM=IDLE.
- Reset outputs: res*_dout=0, res*_wr_en=0, sub_out_rd_en=0, req*_rd_en=0, sub_empty=1.
- The subtract unit must be reset by the same reset event.

Front selection (combinational on current state):
- Both requesters non-empty: sel = !last_grant. Only one non-empty: sel = that requester.
- sub_x/sub_y = sel's operands. With neither non-empty, they show requester 0's operands (don't-care).
- sub_empty = (both req empty) OR (count == MAX_OUTSTANDING).

Front accept (sub_rd_en=1 while sub_empty=0):
- Same cycle: req[sel]_rd_en=1. The other rd_en stays 0.
- Next edge: push sel into the tag FIFO; last_grant <= sel.
- sub_rd_en while sub_empty=1 is ignored: no pop, no push.

Back FSM (2 states; throughput 1 result per 2 cycles):
- IDLE: if !sub_out_empty and tag FIFO non-empty, then assert sub_out_rd_en for 1 cycle. Capture sub_out into res[tag]_dout, pop the tag, latch tgt=tag, and go to WRITE.
- WRITE: if !res[tgt]_full, assert res[tgt]_wr_en for 1 cycle and go to IDLE. Otherwise hold; res[tgt]_dout stays stable and no pop occurs.
- sub_out_empty=0 with the tag FIFO empty is a protocol error. No pop occurs.

Outstanding count:
- +1 on front accept, -1 on back pop (IDLE capture). Both in the same cycle: unchanged.
- Never exceeds MAX_OUTSTANDING or goes below 0. Count == tag FIFO occupancy.
- The tag FIFO wraps its read/write pointers modulo MAX_OUTSTANDING.

Ordering and fairness:
- Results reach each requester in that requester's issue order.
- With both requesters continuously non-empty, grants strictly alternate.
- The arbiter adds no arithmetic; values pass through unmodified.

Optional Feature:
- Macro: SUB_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (32 bits each).
  - Each counts front accepts for its requester; it increments on the accept edge and wraps 0xFFFFFFFF -> 0.
  - Reset clears both to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single stream: req0 x=(10,20,30), y=(3,5,40), req1 empty -> res0 receives (7,15,-10) once. res1_wr_en never asserts. grant_cnt0=1.
- Contention: both requesters hold 4 entries -> grant order 0,1,0,1,0,1,0,1. Each result FIFO receives its 4 results in issue order.
- Credit limit: MAX_OUTSTANDING=8, res0_full=1, req0 holds 12 entries -> exactly 8 accepts, then sub_empty=1. Releasing res0_full drains all 12 in order.
- Back-pressure hold: res1_full=1 in WRITE for 5 cycles -> res1_dout is stable, no sub_out_rd_en, then one res1_wr_en pulse.
- Simultaneous accept and pop: accept and pop land on the same edge -> count unchanged. Tag FIFO wrap after 20 operations gives correct routing.
- Mid-operation reset: assert reset with 3 ops outstanding -> all outputs return to reset values within the same cycle. After release, requester 0 wins the first tie.

Source files
------------

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin sharing of one 3-lane subtract unit between two requesters,
// with in-order result routing. Define SUB_ARB_STATS_EN to add per-requester grant counters.
module sub_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0][DATA_WIDTH-1:0] req0_x_i,
  input  logic [2:0][DATA_WIDTH-1:0] req0_y_i,
  input  logic                       req0_empty_i,
  output logic                       req0_rd_en_o,
  input  logic [2:0][DATA_WIDTH-1:0] req1_x_i,
  input  logic [2:0][DATA_WIDTH-1:0] req1_y_i,
  input  logic                       req1_empty_i,
  output logic                       req1_rd_en_o,
  output logic [2:0][DATA_WIDTH-1:0] sub_x_o,
  output logic [2:0][DATA_WIDTH-1:0] sub_y_o,
  output logic                       sub_empty_o,
  input  logic                       sub_rd_en_i,
  input  logic [2:0][DATA_WIDTH-1:0] sub_out_i,
  input  logic                       sub_out_empty_i,
  output logic                       sub_out_rd_en_o,
  output logic [2:0][DATA_WIDTH-1:0] res0_dout_o,
  output logic                       res0_wr_en_o,
  input  logic                       res0_full_i,
  output logic [2:0][DATA_WIDTH-1:0] res1_dout_o,
  output logic                       res1_wr_en_o,
  input  logic                       res1_full_i
`ifdef SUB_ARB_STATS_EN
  ,
  output logic [31:0]                grant_cnt0_o,
  output logic [31:0]                grant_cnt1_o
`endif
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, WRITE} state_e;
  state_e                       state_q;
  logic                         last_grant_q, tgt_q;
  logic [CW-1:0]                count_q, count_d;
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0]   tag_q;
  logic [2:0][DATA_WIDTH-1:0]   res0_dout_q, res1_dout_q;
  logic                         both, sel, accept, pop, head;
  assign both    = !req0_empty_i && !req1_empty_i;
  assign sel     = both ? !last_grant_q : (req0_empty_i && !req1_empty_i);
  // reset is folded in so the unit sees an empty source while rst_ni is low
  assign sub_empty_o  = !rst_ni || (req0_empty_i && req1_empty_i) || count_q == CW'(MAX_OUTSTANDING);
  assign accept       = sub_rd_en_i && !sub_empty_o;
  assign req0_rd_en_o = accept && !sel;
  assign req1_rd_en_o = accept && sel;
  assign sub_x_o      = sel ? req1_x_i : req0_x_i;
  assign sub_y_o      = sel ? req1_y_i : req0_y_i;
  assign head         = tag_q[rd_ptr_q];
  assign pop          = state_q == IDLE && !sub_out_empty_i && count_q != '0;
  assign sub_out_rd_en_o = pop;
  assign res0_wr_en_o = state_q == WRITE && !tgt_q && !res0_full_i;
  assign res1_wr_en_o = state_q == WRITE && tgt_q && !res1_full_i;
  assign res0_dout_o  = res0_dout_q;
  assign res1_dout_o  = res1_dout_q;
  assign count_d      = count_q + CW'(accept) - CW'(pop);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      tgt_q        <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      res0_dout_q  <= '0;
      res1_dout_q  <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        last_grant_q    <= sel;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        tgt_q    <= head;
        state_q  <= WRITE;
        if (head) res1_dout_q <= sub_out_i;
        else      res0_dout_q <= sub_out_i;
      end else if (res0_wr_en_o || res1_wr_en_o) begin
        state_q <= IDLE;
      end
    end
  end
`ifdef SUB_ARB_STATS_EN
  logic [31:0] grant_cnt0_q, grant_cnt1_q;
  assign grant_cnt0_o = grant_cnt0_q;
  assign grant_cnt1_o = grant_cnt1_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_q + 32'(req0_rd_en_o);
      grant_cnt1_q <= grant_cnt1_q + 32'(req1_rd_en_o);
    end
  end
`endif
endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: directed tables, corner sequences and random traffic against a queue-based model.
module tb_sub_arbiter;
  localparam int MAXO = 8;
  typedef logic [2:0][31:0] vec_t;
  typedef struct { bit r; vec_t x; vec_t y; vec_t e; } vect_t;
  logic clk = 0, rst_n = 0;
  vec_t req0_x, req0_y, req1_x, req1_y, sub_x, sub_y, sub_out, res0_dout, res1_dout;
  logic req0_empty, req1_empty, req0_rd_en, req1_rd_en, sub_empty, sub_rd_en;
  logic sub_out_empty, sub_out_rd_en, res0_wr_en, res1_wr_en, res0_full = 0, res1_full = 0;
`ifdef SUB_ARB_STATS_EN
  logic [31:0] grant_cnt0, grant_cnt1;
`endif
  int errors = 0, checks = 0;
  vec_t q0x[$], q0y[$], q1x[$], q1y[$], subq[$], exp0[$], exp1[$], got0[$], got1[$];
  bit tagq[$], glog[$];
  bit last_g = 1, pend = 0, pend_tgt = 0, sub_hold = 0;
  int rd_pct = 100, both_seen = 0;

  sub_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_x_i(req0_x), .req0_y_i(req0_y), .req0_empty_i(req0_empty), .req0_rd_en_o(req0_rd_en),
    .req1_x_i(req1_x), .req1_y_i(req1_y), .req1_empty_i(req1_empty), .req1_rd_en_o(req1_rd_en),
    .sub_x_o(sub_x), .sub_y_o(sub_y), .sub_empty_o(sub_empty), .sub_rd_en_i(sub_rd_en),
    .sub_out_i(sub_out), .sub_out_empty_i(sub_out_empty), .sub_out_rd_en_o(sub_out_rd_en),
    .res0_dout_o(res0_dout), .res0_wr_en_o(res0_wr_en), .res0_full_i(res0_full),
    .res1_dout_o(res1_dout), .res1_wr_en_o(res1_wr_en), .res1_full_i(res1_full)
`ifdef SUB_ARB_STATS_EN
    , .grant_cnt0_o(grant_cnt0), .grant_cnt1_o(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic vec_t vsub(vec_t a, vec_t b);
    vec_t r;
    for (int i = 0; i < 3; i++) r[i] = a[i] - b[i];
    return r;
  endfunction

  function automatic vec_t rvec();
    vec_t r;
    for (int i = 0; i < 3; i++) r[i] = $urandom;
    return r;
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(bit r, vec_t x, vec_t y);
    if (r) begin q1x.push_back(x); q1y.push_back(y); end
    else begin q0x.push_back(x); q0y.push_back(y); end
  endtask

  task automatic drive();
    req0_empty    = q0x.size() == 0;
    req0_x        = q0x.size() ? q0x[0] : '0;
    req0_y        = q0y.size() ? q0y[0] : '0;
    req1_empty    = q1x.size() == 0;
    req1_x        = q1x.size() ? q1x[0] : '0;
    req1_y        = q1y.size() ? q1y[0] : '0;
    sub_out_empty = sub_hold || subq.size() == 0;
    sub_out       = subq.size() ? subq[0] : '0;
    sub_rd_en     = $urandom_range(99) < rd_pct;
  endtask

  // one clock: check outputs at the negedge against the model, then advance model and environment
  task automatic step();
    bit e0, e1, room, acc, sel, pop, w0, w1, a_acc, a_r0, a_r1, a_pop, a_w0, a_w1;
    vec_t sd, d0, d1;
    drive();
    @(negedge clk);
    e0   = q0x.size() == 0;
    e1   = q1x.size() == 0;
    room = tagq.size() < MAXO;
    acc  = sub_rd_en && !(e0 && e1) && room;
    sel  = (!e0 && !e1) ? !last_g : e0;
    pop  = !pend && !sub_out_empty && tagq.size() > 0;
    w0   = pend && !pend_tgt && !res0_full;
    w1   = pend && pend_tgt && !res1_full;
    chk("sub_empty", sub_empty, (e0 && e1) || !room);
    chk("req0_rd_en", req0_rd_en, acc && !sel);
    chk("req1_rd_en", req1_rd_en, acc && sel);
    chk("sub_out_rd_en", sub_out_rd_en, pop);
    chk("res0_wr_en", res0_wr_en, w0);
    chk("res1_wr_en", res1_wr_en, w1);
    if (acc) chk("sub_operands", vsub(sub_x, sub_y), sel ? vsub(q1x[0], q1y[0]) : vsub(q0x[0], q0y[0]));
    if (w0) chk("res0_dout", res0_dout, exp0.size() ? exp0[0] : 'x);
    if (w1) chk("res1_dout", res1_dout, exp1.size() ? exp1[0] : 'x);
    if (acc && pop) both_seen++;
    a_acc = sub_rd_en && !sub_empty; a_r0 = req0_rd_en; a_r1 = req1_rd_en;
    a_pop = sub_out_rd_en; a_w0 = res0_wr_en; a_w1 = res1_wr_en;
    sd = vsub(sub_x, sub_y); d0 = res0_dout; d1 = res1_dout;
    @(posedge clk);
    #1;
    if (w0 && exp0.size()) void'(exp0.pop_front());
    if (w1 && exp1.size()) void'(exp1.pop_front());
    if (w0 || w1) pend = 0;
    if (pop) begin pend = 1; pend_tgt = tagq.pop_front(); end
    if (acc) begin
      tagq.push_back(sel);
      last_g = sel;
      if (sel) exp1.push_back(vsub(q1x[0], q1y[0]));
      else     exp0.push_back(vsub(q0x[0], q0y[0]));
    end
    if (a_w0) got0.push_back(d0);
    if (a_w1) got1.push_back(d1);
    if (a_pop && subq.size()) void'(subq.pop_front());
    if (a_acc) subq.push_back(sd);
    if (a_r0) glog.push_back(1'b0);
    if (a_r1) glog.push_back(1'b1);
    if (a_r0 && q0x.size()) begin void'(q0x.pop_front()); void'(q0y.pop_front()); end
    if (a_r1 && q1x.size()) begin void'(q1x.pop_front()); void'(q1y.pop_front()); end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((q0x.size() || q1x.size() || tagq.size() || pend) && n < budget) begin
      step();
      n++;
    end
    chk({name, " drain"}, q0x.size() || q1x.size() || tagq.size() || pend, 0);
  endtask

  // asserts reset off-edge, checks outputs follow immediately, clears model and environment
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst sub_empty", sub_empty, 1);
    chk("rst req0_rd_en", req0_rd_en, 0);
    chk("rst req1_rd_en", req1_rd_en, 0);
    chk("rst sub_out_rd_en", sub_out_rd_en, 0);
    chk("rst res0_wr_en", res0_wr_en, 0);
    chk("rst res1_wr_en", res1_wr_en, 0);
    chk("rst res0_dout", res0_dout, 0);
    chk("rst res1_dout", res1_dout, 0);
`ifdef SUB_ARB_STATS_EN
    chk("rst grant_cnt0", grant_cnt0, 0);
    chk("rst grant_cnt1", grant_cnt1, 0);
`endif
    q0x.delete(); q0y.delete(); q1x.delete(); q1y.delete(); subq.delete();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete(); tagq.delete(); glog.delete();
    last_g = 1; pend = 0; pend_tgt = 0; sub_hold = 0; res0_full = 0; res1_full = 0;
    drive();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vect_t tv[4];
    int g, n0, n1, n;
    vec_t dv;
    tv[0] = '{1'b0, {32'd30, 32'd20, 32'd10}, {32'd40, 32'd5, 32'd3}, {32'hFFFFFFF6, 32'd15, 32'd7}};
    tv[1] = '{1'b1, {32'd0, 32'h80000000, 32'h7FFFFFFF}, {32'd0, 32'd1, 32'hFFFFFFFF},
              {32'd0, 32'h7FFFFFFF, 32'h80000000}};
    tv[2] = '{1'b0, {32'hFFFFFFFF, 32'd5, 32'd0}, {32'hFFFFFFFF, 32'd5, 32'd1}, {32'd0, 32'd0, 32'hFFFFFFFF}};
    tv[3] = '{1'b1, {32'd300, 32'd200, 32'd100}, {32'd100, 32'd200, 32'd300}, {32'd200, 32'd0, 32'hFFFFFF38}};
    drive();
    do_reset();
    // single-stream vectors, including overflow wrap of signed lanes
    for (int i = 0; i < 4; i++) begin
      n0 = got0.size(); n1 = got1.size();
      push(tv[i].r, tv[i].x, tv[i].y);
      drain("vector", 40);
      chk("vector res0 count", got0.size(), n0 + (tv[i].r ? 0 : 1));
      chk("vector res1 count", got1.size(), n1 + (tv[i].r ? 1 : 0));
      chk("vector value", tv[i].r ? got1[$] : got0[$], tv[i].e);
    end
`ifdef SUB_ARB_STATS_EN
    chk("stats grant_cnt0", grant_cnt0, 2);
    chk("stats grant_cnt1", grant_cnt1, 2);
`endif
    // contention: strict alternation starting with requester 0
    do_reset();
    for (int i = 0; i < 4; i++) begin push(0, rvec(), rvec()); push(1, rvec(), rvec()); end
    drain("contention", 100);
    chk("contention grants", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) chk("contention order", glog[i], i % 2);
    chk("contention res0 count", got0.size(), 4);
    chk("contention res1 count", got1.size(), 4);
    // credit limit with the back end stalled
    res0_full = 1; sub_hold = 1;
    g = glog.size(); n0 = got0.size();
    for (int i = 0; i < 12; i++) push(0, rvec(), rvec());
    repeat (20) step();
    chk("credit accepts", glog.size() - g, 8);
    chk("credit sub_empty", sub_empty, 1);
    res0_full = 0; sub_hold = 0;
    drain("credit", 200);
    chk("credit results", got0.size() - n0, 12);
    // back-pressure hold in WRITE
    res1_full = 1;
    n1 = got1.size();
    push(1, rvec(), rvec()); push(1, rvec(), rvec());
    n = 0;
    while (!pend && n < 20) begin step(); n++; end
    chk("hold reached WRITE", pend, 1);
    dv = res1_dout;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold dout stable", res1_dout, dv);
      chk("hold no pop", sub_out_rd_en, 0);
      chk("hold no write", res1_wr_en, 0);
    end
    res1_full = 0;
    step();
    chk("hold single write", got1.size() - n1, 1);
    chk("hold written value", got1[$], dv);
    drain("hold", 40);
    // random traffic: wraps the tag FIFO and overlaps accept with pop
    rd_pct = 70;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(2) == 0) push(0, rvec(), rvec());
      if ($urandom_range(2) == 0) push(1, rvec(), rvec());
      res0_full = $urandom_range(3) == 0;
      res1_full = $urandom_range(3) == 0;
      step();
    end
    res0_full = 0; res1_full = 0;
    drain("random", 2000);
    chk("accept and pop on same edge", both_seen > 0, 1);
    // reset with three operations outstanding
    rd_pct = 100; res0_full = 1;
    for (int i = 0; i < 6; i++) push(0, rvec(), rvec());
    push(1, rvec(), rvec());
    g = glog.size();
    n = 0;
    while (glog.size() - g < 4 && n < 20) begin step(); n++; end
    chk("midreset accepts", glog.size() - g, 4);
    do_reset();
    push(1, rvec(), rvec()); push(0, rvec(), rvec());
    n = 0;
    while (glog.size() == 0 && n < 20) begin step(); n++; end
    chk("first tie after reset", glog.size() ? glog[0] : 1'bx, 0);
    drain("after reset", 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
